pipe_stage_reg: RTL and testbench

Parametrised, handshaked pipeline stage register. It replaces the free-running, always-load inter-stage registers (fetch->decode and later) with a valid/ready stage. The stage supports backpressure, flush and an optional skid buffer, which gives full throughput with a registered in_ready. Instruction, PC and commit-info fields are concatenated by the instantiator into one DATA_W payload.

---
 rtl/pipe_stage_reg.sv | 136 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Handshaked valid/ready pipeline stage with optional two-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
module pipe_stage_reg #(
  parameter int                DATA_W     = 257,
  parameter logic [DATA_W-1:0] RESET_DATA = '0,
  parameter bit                SKID_EN    = 1'b1,
  parameter int                CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;

  if (SKID_EN) begin : g_skid
    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              rdy_q, rdy_d;
    logic              in_xfer, out_xfer;

    assign in_xfer  = in_valid && rdy_q;
    assign out_xfer = (state_q != EMPTY) && out_ready;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        EMPTY: if (in_xfer) begin
          state_d = BUSY;
          main_d  = in_data;
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: if (out_xfer) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
      // flush beats every transfer; an offered input is simply dropped
      if (flush) begin
        state_d = EMPTY;
        main_d  = RESET_DATA;
      end
      rdy_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= EMPTY;
        main_q  <= RESET_DATA;
        skid_q  <= '0;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        rdy_q   <= rdy_d;
      end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
  end else begin : g_single
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              in_xfer, out_xfer;

    assign in_ready = !vld_q || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = vld_q && out_ready;

    always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      if (in_xfer) begin
        vld_d  = 1'b1;
        data_d = in_data;
      end else if (out_xfer) begin
        vld_d  = 1'b0;
      end
      if (flush) begin
        vld_d  = 1'b0;
        data_d = RESET_DATA;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q  <= 1'b0;
        data_q <= RESET_DATA;
      end else begin
        vld_q  <= vld_d;
        data_q <= data_d;
      end
    end

    assign out_valid = vld_q;
    assign out_data  = data_q;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a skid (index 0) and a single-entry (index 1) stage side by side and
// compares both against an ordered-queue model of accepted payloads.
module tb_pipe_stage_reg;
  localparam int DW = 16;
  localparam logic [DW-1:0] RST_D = 16'hDEAD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [1:0]         iv = '0, ordy = '0, ir, ov;
  logic [1:0][DW-1:0] id = '0, od;
  logic [2:0]         cnt_s;
  logic [7:0]         cnt_n;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .RESET_DATA(RST_D), .SKID_EN(1'b1), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .stall_cnt(cnt_s));

  pipe_stage_reg #(.DATA_W(DW), .RESET_DATA(RST_D), .SKID_EN(1'b0), .CNT_W(8)) dut_n (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .stall_cnt(cnt_n));

  int n_chk = 0;
  int n_err = 0;

  // model: payloads accepted but not yet delivered, oldest first
  logic [DW-1:0] mq [2][2];
  int            mc [2];
  logic [DW-1:0] last [2];
  int            sc [2];
  int            smax [2] = '{7, 255};

  logic [1:0]         p_iv = '0, p_or = '0;
  logic [1:0][DW-1:0] p_id = '0;
  logic               p_fl = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      mc[m] = 0; last[m] = RST_D; sc[m] = 0;
    end
  endtask

  task automatic step();
    logic er, ev;
    logic [DW-1:0] ed;
    string sfx;
    @(negedge clk);
    iv = p_iv; id = p_id; ordy = p_or; flush = p_fl;
    #1;
    for (int m = 0; m < 2; m++) begin
      sfx = (m == 0) ? "_s" : "_n";
      er = (m == 0) ? (mc[m] < 2) : (mc[m] == 0 || p_or[m]);
      ev = (mc[m] > 0);
      ed = ev ? mq[m][0] : last[m];
      chk({"in_ready", sfx},  32'(ir[m]), 32'(er));
      chk({"out_valid", sfx}, 32'(ov[m]), 32'(ev));
      chk({"out_data", sfx},  32'(od[m]), 32'(ed));
      chk({"stall_cnt", sfx}, (m == 0) ? 32'(cnt_s) : 32'(cnt_n), 32'(sc[m]));
      if (ev && !p_or[m] && sc[m] < smax[m]) sc[m]++;
      if (p_fl) begin
        mc[m] = 0; last[m] = RST_D;
      end else begin
        if (ev && p_or[m]) begin
          last[m] = mq[m][0]; mq[m][0] = mq[m][1]; mc[m]--;
        end
        if (p_iv[m] && er) begin
          mq[m][mc[m]] = p_id[m]; mc[m]++;
        end
      end
    end
  endtask

  // reset asserted between clock edges so the async path is what gets observed
  task automatic do_reset(input int n);
    @(negedge clk);
    #2;
    p_iv = '0; p_or = '0; p_fl = 1'b0;
    iv = '0; ordy = '0; flush = 1'b0;
    rst = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_out_valid", 32'(ov[m]), 32'd0);
      chk("rst_out_data",  32'(od[m]), 32'(RST_D));
      chk("rst_in_ready",  32'(ir[m]), 32'd1);
    end
    chk("rst_stall_s", 32'(cnt_s), 32'd0);
    chk("rst_stall_n", 32'(cnt_n), 32'd0);
    model_clear();
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    p_iv = {v, v}; p_id = {d, d}; p_or = {r, r}; p_fl = f;
    step();
  endtask

  initial begin
    model_clear();
    do_reset(3);

    // streaming, full throughput
    for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i), 1'b1, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    // backpressure into FULL, then drain
    drive(1'b1, 16'h000A, 1'b0, 1'b0);
    drive(1'b1, 16'h000B, 1'b0, 1'b0);
    repeat (4) drive(1'b0, '0, 1'b0, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    // flush in FULL with 0xC offered, then flush in BUSY with input offered
    drive(1'b1, 16'h000A, 1'b0, 1'b0);
    drive(1'b1, 16'h000B, 1'b0, 1'b0);
    drive(1'b1, 16'h000C, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, 16'h000D, 1'b0, 1'b0);
    drive(1'b1, 16'h000E, 1'b1, 1'b1);
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0);

    // single-entry replace-on-same-edge
    drive(1'b1, 16'h0005, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 16'h0006, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // stall counter saturation, then reset while FULL
    do_reset(1);
    drive(1'b1, 16'h0011, 1'b0, 1'b0);
    repeat (10) drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 16'h0012, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("stall_sat", 32'(cnt_s), 32'd7);
    chk("full_rdy", 32'(ir[0]), 32'd0);
    do_reset(2);
    drive(1'b0, '0, 1'b1, 1'b0);

    // randomized valid/ready/flush
    for (int c = 0; c < 8000; c++) begin
      if (c == 4000) do_reset(2);
      for (int m = 0; m < 2; m++) begin
        p_iv[m] = ($urandom_range(0, 3) != 0);
        p_or[m] = ($urandom_range(0, 2) != 0);
        p_id[m] = DW'($urandom);
      end
      p_fl = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
